// File: rtl/shot_clk_btn_cond.sv
// Push-button conditioner: two-flop synchroniser on the raw active-low key,
// press/release debounce FSM, long-hold detector and single-cycle pulses.
// All outputs are registered; pulses are mutually exclusive by construction.
module shot_clk_btn_cond #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LONG_CYCLES     = 100000000,
   parameter int unsigned CNT_W           = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic btn_level
);

   typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} state_t;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   logic             sync1_q, sync2_q;
   logic             pressed;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             press_pulse_q, press_pulse_d;
   logic             release_pulse_q, release_pulse_d;
   logic             long_pulse_q, long_pulse_d;
   logic             btn_level_q, btn_level_d;

   // Bring the asynchronous key into the clk domain; idle value is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= btn_n;
         sync2_q <= sync1_q;
      end
   end

   assign pressed = ~sync2_q;

   // Debounce FSM next-state, counters and pulse decisions.
   always_comb begin
      state_d         = state_q;
      deb_cnt_d       = deb_cnt_q;
      hold_cnt_d      = hold_cnt_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      long_pulse_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pressed) begin
               state_d   = DB_PRESS;
               deb_cnt_d = '0;
            end
         end
         DB_PRESS: begin
            if (!pressed) begin
               state_d = IDLE;                 // bounce rejected silently
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d       = HELD;
               press_pulse_d = 1'b1;
               hold_cnt_d    = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + ONE;
            end
         end
         HELD: begin
            if (!pressed) begin
               state_d   = DB_REL;             // hold_cnt kept for a possible bounce
               deb_cnt_d = '0;
            end else if (hold_cnt_q < LONG_MAX) begin
               hold_cnt_d   = hold_cnt_q + ONE; // saturates: one long_pulse per press
               long_pulse_d = (hold_cnt_q == LONG_LAST);
            end
         end
         DB_REL: begin
            if (pressed) begin
               state_d = HELD;                 // release bounce, resume hold count
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d         = IDLE;
               release_pulse_d = 1'b1;
            end else begin
               deb_cnt_d = deb_cnt_q + ONE;
            end
         end
         default: state_d = IDLE;
      endcase
      btn_level_d = (state_d == HELD) || (state_d == DB_REL);
   end

   // Register FSM state, counters and all outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         deb_cnt_q       <= '0;
         hold_cnt_q      <= '0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_pulse_q    <= 1'b0;
         btn_level_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         deb_cnt_q       <= deb_cnt_d;
         hold_cnt_q      <= hold_cnt_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         long_pulse_q    <= long_pulse_d;
         btn_level_q     <= btn_level_d;
      end
   end

   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign long_pulse    = long_pulse_q;
   assign btn_level     = btn_level_q;

endmodule

// File: tb/tb_shot_clk_btn_cond.sv
// Bench for shot_clk_btn_cond: run-length reference model checked every
// cycle, directed scenarios pinned with literal cycle offsets, then random keys.
module tb_shot_clk_btn_cond;

   localparam int D = 4;
   localparam int L = 20;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_n = 1'b1;
   logic press_pulse, release_pulse, long_pulse, btn_level;

   shot_clk_btn_cond #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .btn_n(btn_n),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .btn_level(btn_level)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: key delayed two samples; debounced level flips after
   // D+1 consecutive samples disagreeing with it; long fires on the L-th
   // pressed sample taken while held with no pending release run.
   logic m_s1 = 1'b1, m_s2 = 1'b1;
   bit   m_lvl = 0;
   int   m_run = 0, m_held = 0;
   bit   e_press = 0, e_rel = 0, e_long = 0, e_lvl = 0;

   always @(posedge clk or negedge rst) begin
      bit pr, lv, ep, er, el;
      int rn, hd;
      if (!rst) begin
         m_s1 <= 1'b1; m_s2 <= 1'b1; m_lvl <= 0; m_run <= 0; m_held <= 0;
         e_press <= 0; e_rel <= 0; e_long <= 0; e_lvl <= 0;
      end else begin
         pr = !m_s2; lv = m_lvl; rn = m_run; hd = m_held;
         ep = 0; er = 0; el = 0;
         if (pr != lv) begin
            rn = rn + 1;
            if (rn == D + 1) begin
               lv = pr; rn = 0;
               if (pr) begin ep = 1; hd = 0; end
               else er = 1;
            end
         end else begin
            if (lv && rn == 0 && hd < L) begin
               hd = hd + 1;
               el = (hd == L);
            end
            rn = 0;
         end
         m_s2 <= m_s1; m_s1 <= btn_n;
         m_lvl <= lv; m_run <= rn; m_held <= hd;
         e_press <= ep; e_rel <= er; e_long <= el; e_lvl <= lv;
      end
   end

   // Per-cycle comparison against the model, plus pulse bookkeeping.
   int press_cyc = -1, release_cyc = -1, long_cyc = -1;
   int n_press = 0, n_rel = 0, n_long = 0;

   always @(negedge clk) begin
      chk("press_pulse", int'(press_pulse), int'(e_press));
      chk("release_pulse", int'(release_pulse), int'(e_rel));
      chk("long_pulse", int'(long_pulse), int'(e_long));
      chk("btn_level", int'(btn_level), int'(e_lvl));
      chk("pulse_exclusive",
          (int'(press_pulse) + int'(release_pulse) + int'(long_pulse)) <= 1 ? 1 : 0, 1);
      if (press_pulse)   begin press_cyc <= cyc;   n_press <= n_press + 1; end
      if (release_pulse) begin release_cyc <= cyc; n_rel <= n_rel + 1;     end
      if (long_pulse)    begin long_cyc <= cyc;    n_long <= n_long + 1;   end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c, p, r, np, nr, nl;

      // Reset state
      tick(3);
      chk("reset_press", int'(press_pulse), 0);
      chk("reset_release", int'(release_pulse), 0);
      chk("reset_long", int'(long_pulse), 0);
      chk("reset_level", int'(btn_level), 0);
      rst = 1'b1;
      tick(5);

      // Clean press followed by a long hold and release
      np = n_press; nr = n_rel; nl = n_long;
      c = cyc; btn_n = 1'b0;
      tick(7);
      chk("clean_press_cycle", press_cyc, c + 7);
      chk("clean_press_level", int'(btn_level), 1);
      p = press_cyc;
      tick(20);
      chk("long_cycle", long_cyc, p + 20);
      tick(20);
      chk("long_count", n_long - nl, 1);
      c = cyc; btn_n = 1'b1;
      tick(7);
      chk("release_cycle", release_cyc, c + 7);
      chk("release_level", int'(btn_level), 0);
      chk("clean_press_count", n_press - np, 1);
      chk("clean_release_count", n_rel - nr, 1);
      tick(5);

      // Bounce reject: 3 low / 5 high, three times
      np = n_press; nr = n_rel; nl = n_long;
      for (int i = 0; i < 3; i++) begin
         btn_n = 1'b0; tick(3);
         btn_n = 1'b1; tick(5);
      end
      tick(4);
      chk("bounce_press", n_press - np, 0);
      chk("bounce_release", n_rel - nr, 0);
      chk("bounce_long", n_long - nl, 0);
      chk("bounce_level", int'(btn_level), 0);

      // Release bounce while held: long_pulse delayed by the DB_REL excursion
      np = n_press; nr = n_rel;
      c = cyc; btn_n = 1'b0;
      tick(7);
      chk("rb_press_cycle", press_cyc, c + 7);
      p = press_cyc;
      tick(10);
      btn_n = 1'b1; tick(2);
      btn_n = 1'b0; tick(20);
      chk("rb_long_cycle", long_cyc, p + 23);
      chk("rb_no_release", n_rel - nr, 0);
      chk("rb_single_press", n_press - np, 1);
      btn_n = 1'b1; tick(10);

      // Short press: 6 stable low cycles
      nl = n_long;
      c = cyc; btn_n = 1'b0;
      tick(6);
      r = cyc; btn_n = 1'b1;
      tick(10);
      chk("short_press_cycle", press_cyc, c + 7);
      chk("short_release_cycle", release_cyc, r + 7);
      chk("short_no_long", n_long - nl, 0);

      // Reset mid-hold with key still down
      btn_n = 1'b0;
      tick(12);
      chk("pre_reset_level", int'(btn_level), 1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_press", int'(press_pulse), 0);
      chk("midrst_release", int'(release_pulse), 0);
      chk("midrst_long", int'(long_pulse), 0);
      chk("midrst_level", int'(btn_level), 0);
      tick(1);
      c = cyc; rst = 1'b1;
      tick(7);
      chk("postrst_press_cycle", press_cyc, c + 7);
      btn_n = 1'b1; tick(10);

      // Random key activity with occasional resets
      for (int i = 0; i < 250; i++) begin
         btn_n = 1'($urandom_range(0, 1));
         tick($urandom_range(1, 12));
         if ($urandom_range(0, 29) == 0) begin
            rst = 1'b0; tick($urandom_range(1, 2)); rst = 1'b1;
         end
      end
      btn_n = 1'b1;
      tick(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
